// File: rtl/pulse_queue_pkg.sv
// pulse_queue_pkg: shared FSM encoding and timing defaults for the pulse request queue
package pulse_queue_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} pq_state_t;
  localparam int BUSY_TIMEOUT_DEF = 8;
endpackage

// File: rtl/sat_updown_counter.sv
// sat_updown_counter: up/down counter that saturates at all-ones and strobes on a dropped increment
module sat_updown_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         ovf
);
  assign ovf = inc && !dec && &count;
  // simultaneous inc and dec cancel; a saturated increment is dropped
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && !dec && !(&count)) count <= count + 1'b1;
    else if (dec && !inc && |count) count <= count - 1'b1;
endmodule

// File: rtl/pulse_request_queue.sv
// pulse_request_queue: queues request events and issues them one at a time to a handshake synchronizer
module pulse_request_queue
  import pulse_queue_pkg::*;
#(
  parameter int CNT_W        = 4,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic             clk_fast,
  input  logic             reset,
  input  logic             event_in,
  input  logic             synchro_busy,
  input  logic             clear_flags,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending_count,
  output logic             queue_empty,
  output logic             overflow,
  output logic             handshake_err
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  pq_state_t state, state_nx;
  logic [TW-1:0] tmo;
  logic issue, timeout, cnt_ovf;
  assign issue = state_nx == ISSUE;
  assign queue_empty = pending_count == '0;
  sat_updown_counter #(.W(CNT_W)) u_cnt (
    .clk  (clk_fast),
    .rst  (reset),
    .inc  (event_in),
    .dec  (issue),
    .count(pending_count),
    .ovf  (cnt_ovf)
  );
  // next state; tmo counts edges since the pulse was issued, so busy gets BUSY_TIMEOUT edges to appear
  always_comb begin
    state_nx = state;
    timeout = 1'b0;
    case (state)
      IDLE:    state_nx = (|pending_count && !synchro_busy) ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT_HI;
      WAIT_HI: begin
        timeout = !synchro_busy && tmo == TW'(BUSY_TIMEOUT - 1);
        state_nx = synchro_busy ? WAIT_LO : timeout ? IDLE : WAIT_HI;
      end
      WAIT_LO: state_nx = synchro_busy ? WAIT_LO : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state, registered pulse, handshake timer and sticky flags (a set beats a clear)
  always_ff @(posedge clk_fast)
    if (reset) begin
      state <= IDLE;
      pulse_out <= 1'b0;
      tmo <= '0;
      overflow <= 1'b0;
      handshake_err <= 1'b0;
    end else begin
      state <= state_nx;
      pulse_out <= issue;
      tmo <= (state == IDLE) ? '0 : tmo + 1'b1;
      overflow <= cnt_ovf || (overflow && !clear_flags);
      handshake_err <= timeout || (handshake_err && !clear_flags);
    end
endmodule

// File: tb/tb_pulse_request_queue.sv
// tb_pulse_request_queue: directed scenarios checked every cycle against a behavioural queue model
module tb_pulse_request_queue;
  localparam int CNT_W = 4;
  localparam int T = 8;
  localparam int MAXC = 15;
  logic clk_fast = 1'b0;
  logic reset = 1'b1;
  logic event_in = 1'b0;
  logic synchro_busy = 1'b0;
  logic clear_flags = 1'b0;
  logic pulse_out, queue_empty, overflow, handshake_err;
  logic [CNT_W-1:0] pending_count;
  int n_checks = 0;
  int n_fail = 0;
  int busy_mode = 0;
  int sync_t = 100;
  int cyc = 0;
  int pulses = 0;
  int peak = 0;
  int cp, ce;
  int m_cnt = 0;
  int m_age = 0;
  bit m_ovf, m_err, m_active, m_got, m_valid, m_issue, m_eset, m_oset;

  pulse_request_queue #(.CNT_W(CNT_W), .BUSY_TIMEOUT(T)) dut (
    .clk_fast     (clk_fast),
    .reset        (reset),
    .event_in     (event_in),
    .synchro_busy (synchro_busy),
    .clear_flags  (clear_flags),
    .pulse_out    (pulse_out),
    .pending_count(pending_count),
    .queue_empty  (queue_empty),
    .overflow     (overflow),
    .handshake_err(handshake_err)
  );

  always #5 clk_fast = ~clk_fast;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // model: a handshake is outstanding from issue until busy has risen and fallen, or busy never rose in time
  initial forever begin
    @(posedge clk_fast);
    if (reset) begin
      m_cnt = 0; m_ovf = 0; m_err = 0; m_active = 0; m_valid = 1;
    end else begin
      m_issue = 0; m_eset = 0;
      if (!m_active) begin
        if (m_cnt > 0 && !synchro_busy) begin
          m_issue = 1; m_active = 1; m_got = 0; m_age = 0;
        end
      end else begin
        if (m_age >= 1) begin
          if (!m_got) begin
            if (synchro_busy) m_got = 1;
            else if (m_age == T - 1) begin m_eset = 1; m_active = 0; end
          end else if (!synchro_busy) m_active = 0;
        end
        m_age++;
      end
      m_oset = event_in && !m_issue && m_cnt == MAXC;
      if (event_in && !m_issue && m_cnt < MAXC) m_cnt++;
      else if (m_issue && !event_in) m_cnt--;
      m_ovf = m_oset || (m_ovf && !clear_flags);
      m_err = m_eset || (m_err && !clear_flags);
    end
  end

  always @(negedge clk_fast)
    if (m_valid) begin
      check("pulse_out", 32'(pulse_out), 32'(m_active && m_age == 0));
      check("pending_count", 32'(pending_count), m_cnt);
      check("queue_empty", 32'(queue_empty), 32'(m_cnt == 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("handshake_err", 32'(handshake_err), 32'(m_err));
    end

  // downstream synchronizer: busy rises 2 cycles after a pulse and stays up 6 cycles
  task automatic tick();
    @(negedge clk_fast);
    cyc++;
    if (pulse_out === 1'b1) begin pulses++; sync_t = 0; end
    else if (sync_t < 100) sync_t++;
    synchro_busy = busy_mode == 1 ? 1'b1 : busy_mode == 2 ? 1'b0 : (sync_t >= 2 && sync_t <= 7);
    if (int'(pending_count) > peak) peak = int'(pending_count);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    run(2);
    reset = 1'b0;
    check("rst_pending", 32'(pending_count), 0);
    check("rst_pulse", 32'(pulse_out), 0);
    check("rst_empty", 32'(queue_empty), 1);
    check("rst_flags", {30'd0, overflow, handshake_err}, 0);
    // scenario 1: single event, pulse one edge after the count appears
    pulses = 0;
    event_in = 1'b1; tick(); event_in = 1'b0;
    check("s1_count_after_event", 32'(pending_count), 1);
    check("s1_no_pulse_yet", 32'(pulse_out), 0);
    tick();
    check("s1_pulse", 32'(pulse_out), 1);
    check("s1_count_issued", 32'(pending_count), 0);
    tick();
    check("s1_pulse_single", 32'(pulse_out), 0);
    check("s1_empty", 32'(queue_empty), 1);
    run(2);
    check("s1_pulses", pulses, 1);
    // scenario 2: burst of 5 queued during the previous handshake's busy window
    pulses = 0; peak = 0;
    event_in = 1'b1; run(5); event_in = 1'b0;
    run(80);
    check("s2_pulses", pulses, 5);
    check("s2_peak", peak, 5);
    check("s2_overflow", 32'(overflow), 0);
    // scenario 3: saturation with busy held; last event shares its edge with a clear
    busy_mode = 1; synchro_busy = 1'b1; tick();
    pulses = 0;
    event_in = 1'b1; run(19);
    clear_flags = 1'b1; tick();
    event_in = 1'b0; clear_flags = 1'b0;
    check("s3_saturated", 32'(pending_count), 15);
    check("s3_overflow_set_wins", 32'(overflow), 1);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    check("s3_overflow_cleared", 32'(overflow), 0);
    busy_mode = 0; synchro_busy = 1'b0;
    run(185);
    check("s3_pulses", pulses, 15);
    check("s3_empty", 32'(queue_empty), 1);
    // scenario 4: busy never rises, error after the timeout window
    busy_mode = 2; synchro_busy = 1'b0; tick();
    pulses = 0; cp = -1; ce = -1;
    event_in = 1'b1; tick(); event_in = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (pulse_out === 1'b1 && cp < 0) cp = cyc;
      if (handshake_err === 1'b1 && ce < 0) ce = cyc;
    end
    check("s4_err_delay", ce - cp, T);
    check("s4_pulses", pulses, 1);
    check("s4_err", 32'(handshake_err), 1);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    check("s4_err_cleared", 32'(handshake_err), 0);
    // scenario 5: event on the issue edge leaves the count unchanged
    busy_mode = 1; synchro_busy = 1'b1; tick();
    pulses = 0;
    event_in = 1'b1; run(3); event_in = 1'b0;
    check("s5_count_before", 32'(pending_count), 3);
    busy_mode = 0; synchro_busy = 1'b0; event_in = 1'b1;
    tick(); event_in = 1'b0;
    check("s5_pulse", 32'(pulse_out), 1);
    check("s5_count_same_edge", 32'(pending_count), 3);
    run(60);
    check("s5_pulses", pulses, 4);
    // scenario 6: reset during WAIT_LO with 4 queued, event on the reset edge ignored
    pulses = 0;
    event_in = 1'b1; tick(); run(4); event_in = 1'b0;
    check("s6_count_before", 32'(pending_count), 4);
    check("s6_busy_high", 32'(synchro_busy), 1);
    reset = 1'b1; event_in = 1'b1; tick(); reset = 1'b0; event_in = 1'b0;
    check("s6_count_reset", 32'(pending_count), 0);
    check("s6_pulse_reset", 32'(pulse_out), 0);
    run(30);
    check("s6_no_more_pulses", pulses, 1);
    check("s6_empty", 32'(queue_empty), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
